// File: rtl/servo_slew_limiter.sv
// servo_slew_limiter: command front end for the servo pulse-width stage.
// Accepts target angles over valid/ready, buffers one pending command and
// slews angle_out toward the active target by at most STEP degrees per frame.
// Optional feature macro: SLEW_SETTLE_EN adds a SETTLE state that holds for
// HOLD_FRAMES frames after each arrival before the next target is loaded.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is simply "pending slot empty", so it
// never depends on cmd_valid, and cmd_valid/cmd_angle must stay stable until
// that transfer edge.
module servo_slew_limiter #(
  parameter int FRAME_TICKS = 1000000,
  parameter int STEP        = 2,
  parameter int MAX_ANGLE   = 180,
  parameter int RESET_ANGLE = 90,
  parameter int HOLD_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_angle,
  output logic       cmd_ready,
  output logic [7:0] angle_out,
  output logic       moving,
  output logic       done,
  output logic       clamp_err,
  output logic       frame_tick,
  output logic [1:0] state_dbg
);

  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(FRAME_TICKS - 1);
  localparam logic [7:0]      MAX_A    = 8'(MAX_ANGLE);
  localparam logic [7:0]      RST_A    = 8'(RESET_ANGLE);
  localparam logic [7:0]      STEP_U   = 8'(STEP);
  localparam logic signed [8:0] STEP_S = 9'(STEP);

  // Parameter sanity: fail elaboration on values the datapath cannot honour.
  if (STEP < 1 || STEP > 180 || FRAME_TICKS < 2 || HOLD_FRAMES < 1 ||
      MAX_ANGLE > 255 || RESET_ANGLE > MAX_ANGLE) begin : g_param_check
    $error("servo_slew_limiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1
`ifdef SLEW_SETTLE_EN
    ,
    S_SETTLE = 2'd2
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          pend_valid;
  logic [7:0]    pend_angle;
  logic [7:0]    target_q, target_d;
  logic [7:0]    angle_q, angle_d;
  logic          done_d;
  logic          take;
  logic          accept;
  logic signed [8:0] diff;
  logic signed [8:0] mag;
  logic          near;

`ifdef SLEW_SETTLE_EN
  localparam int SW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(HOLD_FRAMES - 1);
  logic [SW-1:0] settle_q, settle_d;
`endif

  assign frame_tick = (cnt_q == LAST_CNT);
  assign cmd_ready  = ~pend_valid;
  assign accept     = cmd_valid & cmd_ready;
  assign angle_out  = angle_q;
  assign moving     = (state_q == S_MOVE);
  assign state_dbg  = state_q;

  // Signed distance to the target; the final step is an exact load, so
  // angle_out never leaves 0..MAX_ANGLE.
  assign diff = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
  assign mag  = diff[8] ? -diff : diff;
  assign near = (mag <= STEP_S);

  // Free-running frame counter, independent of the slew state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (frame_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Single-entry pending register; out-of-range commands are clamped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_angle <= '0;
      clamp_err  <= 1'b0;
    end else begin
      clamp_err <= accept && (cmd_angle > MAX_A);
      if (accept) begin
        pend_valid <= 1'b1;
        pend_angle <= (cmd_angle > MAX_A) ? MAX_A : cmd_angle;
      end else if (take) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Next-state and datapath decisions for the slew FSM.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    angle_d  = angle_q;
    done_d   = 1'b0;
    take     = 1'b0;
`ifdef SLEW_SETTLE_EN
    settle_d = settle_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pend_valid) begin
          target_d = pend_angle;
          take     = 1'b1;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        if (frame_tick) begin
          if (near) begin
            angle_d = target_q;
            done_d  = 1'b1;
`ifdef SLEW_SETTLE_EN
            settle_d = '0;
            state_d  = S_SETTLE;
`else
            state_d  = S_IDLE;
`endif
          end else if (!diff[8]) begin
            angle_d = angle_q + STEP_U;
          end else begin
            angle_d = angle_q - STEP_U;
          end
        end
      end
`ifdef SLEW_SETTLE_EN
      S_SETTLE: begin
        if (frame_tick) begin
          if (settle_q == SETTLE_LAST) begin
            state_d = S_IDLE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any motion in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= RST_A;
      angle_q  <= RST_A;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      angle_q  <= angle_d;
      done     <= done_d;
    end
  end

`ifdef SLEW_SETTLE_EN
  // Settle-frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
    end else begin
      settle_q <= settle_d;
    end
  end
`endif

endmodule

// File: tb/tb_servo_slew_limiter.sv
// Self-checking bench for servo_slew_limiter with FRAME_TICKS=10, STEP=2,
// HOLD_FRAMES=3. Expected angle steps and arrivals are queued when commands
// are issued; a monitor pops and compares on every angle change and done.
module tb_servo_slew_limiter;

  localparam int FT = 10;
`ifdef SLEW_SETTLE_EN
  localparam int LOAD_GAP = 3 * FT + 1;
`else
  localparam int LOAD_GAP = 1;
`endif

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_angle;
  logic       cmd_ready;
  logic [7:0] angle_out;
  logic       moving;
  logic       done;
  logic       clamp_err;
  logic       frame_tick;
  logic [1:0] state_dbg;

  servo_slew_limiter #(
    .FRAME_TICKS(FT),
    .STEP(2),
    .MAX_ANGLE(180),
    .RESET_ANGLE(90),
    .HOLD_FRAMES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_angle(cmd_angle),
    .cmd_ready(cmd_ready),
    .angle_out(angle_out),
    .moving(moving),
    .done(done),
    .clamp_err(clamp_err),
    .frame_tick(frame_tick),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] done_q[$];
  int last_done_cyc = -1;
  int load_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ramp(input int first, input int last, input int stride);
    for (int v = first; (stride > 0) ? (v <= last) : (v >= last); v += stride)
      exp_q.push_back(8'(v));
  endtask

  // Monitor: compares every angle change and every done pulse.
  logic [7:0] prev_angle = 8'd90;
  logic       prev_tick = 1'b0;
  logic       prev_moving = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_angle  = angle_out;
      prev_tick   = 1'b0;
      prev_moving = 1'b0;
    end else begin
      if (angle_out != prev_angle) begin
        check("step_after_tick", int'(prev_tick), 1);
        if (exp_q.size() == 0) begin
          check("angle_unexpected", int'(angle_out), int'(prev_angle));
        end else begin
          check("angle_step", int'(angle_out), int'(exp_q.pop_front()));
        end
        prev_angle = angle_out;
      end
      if (done) begin
        check("moving_low_at_done", int'(moving), 0);
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          check("done_angle", int'(angle_out), int'(done_q.pop_front()));
        end
        last_done_cyc = cyc;
      end
      if (moving && !prev_moving) load_cyc = cyc;
      prev_moving = moving;
      prev_tick   = frame_tick;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input int exp_clamp, output int acc_cyc);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = a;
    while (!cmd_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("send_timeout", 0, 1);
      cmd_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    check("clamp_err", int'(clamp_err), exp_clamp);
    check("ready_after_accept", int'(cmd_ready), 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", done_q.size(), 0);
  endtask

  // Asynchronous reset asserted mid-cycle, released away from the clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_angle", int'(angle_out), 90);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_moving", int'(moving), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int acc;
  int n;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_angle = 8'd0;
    repeat (3) @(negedge clk);
    check("init_angle", int'(angle_out), 90);
    check("init_ready", int'(cmd_ready), 1);
    check("init_moving", int'(moving), 0);
    check("init_done", int'(done), 0);
    check("init_clamp", int'(clamp_err), 0);
    check("init_tick", int'(frame_tick), 0);
    check("init_state", int'(state_dbg), 0);
    #1;
    reset = 1'b0;

    // Basic move 90 -> 100.
    exp_q.push_back(8'd92); exp_q.push_back(8'd94); exp_q.push_back(8'd96);
    exp_q.push_back(8'd98); exp_q.push_back(8'd100);
    done_q.push_back(8'd100);
    send(8'd100, 0, acc);
    wait_done();

    // Odd final step 90 -> 95, then clamped 200 -> 180.
    do_reset();
    exp_q.push_back(8'd92); exp_q.push_back(8'd94); exp_q.push_back(8'd95);
    done_q.push_back(8'd95);
    send(8'd95, 0, acc);
    wait_done();
    push_ramp(97, 179, 2);
    exp_q.push_back(8'd180);
    done_q.push_back(8'd180);
    send(8'd200, 1, acc);
    wait_done();

    // Queueing: 80, then 60 during motion, then a stalled 70.
    push_ramp(178, 80, -2);
    done_q.push_back(8'd80);
    send(8'd80, 0, acc);
    repeat (50) @(negedge clk);
    check("moving_when_queued", int'(moving), 1);
    push_ramp(78, 60, -2);
    done_q.push_back(8'd60);
    send(8'd60, 0, acc);
    push_ramp(62, 70, 2);
    done_q.push_back(8'd70);
    send(8'd70, 0, acc);
    check("load_gap_after_done", load_cyc - last_done_cyc, LOAD_GAP);
    check("third_accept_cycle", acc, load_cyc + 1);
    wait_done();

    // Reset mid-move toward 0 with a command pending.
    do_reset();
    push_ramp(88, 70, -2);
    send(8'd0, 0, acc);
    send(8'd50, 0, acc);
    n = 0;
    while (angle_out != 8'd70 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_70", int'(angle_out), 70);
    #2;
    reset = 1'b1;
    #1;
    check("midmove_rst_angle", int'(angle_out), 90);
    check("midmove_rst_ready", int'(cmd_ready), 1);
    check("midmove_rst_moving", int'(moving), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_angle", int'(angle_out), 90);
    check("post_rst_state", int'(state_dbg), 0);
    check("post_rst_ready", int'(cmd_ready), 1);

    // Final report.
    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
